tick_timer_scheduler: RTL and testbench
=======================================

Name: tick_timer_scheduler

Overview:
- Shares one millisecond timebase among NUM_CH independent countdown timers for the vending-machine controller, e.g. dispense timeout, coin-return hold and idle display blanking.
- Generates a single-cycle clock-enable tick from clk. It never drives a derived clock, and all logic stays in the clk domain.
- Each channel runs a start/cancel/expire handshake. Requesters are the vending FSM and the display/coin logic.

Parameters:
- TICK_DIV, 100000, clk cycles per tick (100 MHz -> 1 ms); must be >= 2
- NUM_CH, 4, number of timer channels
- CNT_W, 16, countdown width in ticks (max 65535 ms)

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  NUM_CH  per-channel load/start strobe, one cycle
- cancel  input  NUM_CH  per-channel abort strobe, one cycle
- load_val  input  NUM_CH*CNT_W  per-channel duration in ticks; channel i uses bits [i*CNT_W +: CNT_W]
- rd_sel  input  clog2(NUM_CH)  channel select for readback
- busy  output  NUM_CH  channel counting, registered
- expired  output  NUM_CH  one-cycle pulse at expiry, registered
- tick_1ms  output  1  one-cycle timebase pulse, registered
- rd_remaining  output  CNT_W  remaining count of channel rd_sel, combinational mux of channel registers

Behaviour:
- Reset (async, active-high) clears:
  - prescaler and all channel counts to 0
  - tick_1ms, busy and expired to 0
  - all channels to IDLE
- Reset mid-count aborts every channel silently; no expired pulse is produced.
- Prescaler runs free and is not synchronised to start:
  - counts 0..TICK_DIV-1, then wraps to 0
  - tick_1ms <= (prescaler == TICK_DIV-1)
  - tick_1ms is high exactly 1 cycle per TICK_DIV cycles
  - first high: the cycle after the TICK_DIV-th clk edge following reset release
- Channel decrements use the registered tick_1ms. A channel acts on the edge where tick_1ms==1.
- Channel FSM states: IDLE, RUN. busy == (state == RUN).
- Per channel, evaluated every edge in this priority order:
  1. cancel=1: go to IDLE, count<=0, no expired. cancel beats a simultaneous start.
  2. start=1, load_val=0: stay or go IDLE, expired<=1 next cycle, busy stays 0.
  3. start=1, load_val=N>0: count<=N, go to RUN. Applies from IDLE and from RUN (restart/reload). Start beats a simultaneous tick decrement and a simultaneous expiry; no expired pulse is produced.
  4. RUN and tick with count>1: count<=count-1.
  5. RUN and tick with count==1: count<=0, go to IDLE, expired<=1.
  6. Otherwise, hold.
- expired defaults to 0 every cycle and is never held for more than one cycle.
- Start-to-expiry latency for N>0 is between (N-1)*TICK_DIV+1 and N*TICK_DIV cycles. This is a documented ±1 tick granularity.
- Channels are fully independent. Several may expire in the same cycle, and multiple expired bits may be high together.
- No underflow: count never decrements below 0. IDLE ignores ticks.
- rd_remaining reflects the registered count of channel rd_sel. An out-of-range rd_sel returns 0.

Test Plan:
1. TICK_DIV=4, release reset, no starts -> tick_1ms high after the 4th edge, then every 4th cycle; busy=0 and expired=0 throughout.
2. Pulse start[0] with load_val ch0=3 -> busy[0]=1 next cycle. rd_remaining (rd_sel=0) goes 3,2,1 on successive ticks. On the 3rd tick edge: busy[0]=0, expired[0]=1 for exactly 1 cycle, count=0.
3. start[1] with load_val=0 -> expired[1]=1 for 1 cycle on the next cycle; busy[1] never asserts.
4. Channel 2 loaded 5, cancel[2] after 2 ticks -> busy[2]=0 next cycle, no expired[2] ever. Then start[2]+cancel[2] in the same cycle -> channel stays IDLE.
5. Channel 3 loaded 2, start[3] again with 4 on the cycle tick_1ms=1 and count==1 -> no expired pulse, count=4. Expiry occurs 4 ticks later.
6. Channels 0 and 1 loaded 2 in the same cycle -> expired=4'b0011 in one cycle. Separately, assert reset while 3 channels RUN -> all outputs 0 immediately, no expired after release.

Source files
------------

// File: rtl/tick_timer_scheduler.sv
// Shared millisecond timebase driving NUM_CH independent countdown timers.
// Each channel implements a start/cancel/expire handshake. All logic runs on clk.

module tick_timer_channel #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_i,
  input  logic             start_i,
  input  logic             cancel_i,
  input  logic [CNT_W-1:0] load_i,
  output logic             busy_o,
  output logic             expired_o,
  output logic [CNT_W-1:0] count_o
);
  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             exp_q;

  // Cancel wins over start, and start wins over a same-edge tick or expiry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      exp_q   <= 1'b0;
    end else begin
      exp_q <= 1'b0;
      if (cancel_i) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        busy_q  <= 1'b0;
      end else if (start_i && (load_i == '0)) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        busy_q  <= 1'b0;
        exp_q   <= 1'b1;
      end else if (start_i) begin
        state_q <= RUN;
        cnt_q   <= load_i;
        busy_q  <= 1'b1;
      end else if ((state_q == RUN) && tick_i) begin
        if (cnt_q > ONE) begin
          cnt_q <= cnt_q - ONE;
        end else begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          exp_q   <= 1'b1;
        end
      end
    end
  end

  assign busy_o    = busy_q;
  assign expired_o = exp_q;
  assign count_o   = cnt_q;
endmodule

module tick_timer_scheduler #(
  parameter int unsigned TICK_DIV = 100000,  // must be >= 2
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CNT_W    = 16,
  localparam int unsigned SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       cancel,
  input  logic [NUM_CH*CNT_W-1:0] load_val,
  input  logic [SEL_W-1:0]        rd_sel,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       expired,
  output logic                    tick_1ms,
  output logic [CNT_W-1:0]        rd_remaining
);
  localparam int unsigned PRE_W = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0]              pre_q;
  logic                          tick_q;
  logic [NUM_CH-1:0][CNT_W-1:0]  cnt;

  // Free-running prescaler; never resynchronised by channel starts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
      tick_q <= (pre_q == PRE_LAST);
    end
  end

  assign tick_1ms = tick_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tick_timer_channel #(.CNT_W(CNT_W)) u_ch (
      .clk       (clk),
      .reset     (reset),
      .tick_i    (tick_q),
      .start_i   (start[g]),
      .cancel_i  (cancel[g]),
      .load_i    (load_val[g*CNT_W +: CNT_W]),
      .busy_o    (busy[g]),
      .expired_o (expired[g]),
      .count_o   (cnt[g])
    );
  end

  // Unmatched select codes fall through to zero.
  always_comb begin
    rd_remaining = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (rd_sel == SEL_W'(i)) rd_remaining = cnt[i];
  end
endmodule

// File: tb/tb_tick_timer_scheduler.sv
// Directed bench for tick_timer_scheduler with a 4-cycle timebase.
// Edge numbers below count clk rising edges after reset release.

module tb_tick_timer_scheduler;
  localparam int TICK_DIV = 4;
  localparam int NUM_CH   = 4;
  localparam int CNT_W    = 16;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NUM_CH-1:0]       start, cancel;
  logic [NUM_CH*CNT_W-1:0] load_val;
  logic [1:0]              rd_sel;
  logic [NUM_CH-1:0]       busy, expired;
  logic                    tick_1ms;
  logic [CNT_W-1:0]        rd_remaining;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  tick_timer_scheduler #(.TICK_DIV(TICK_DIV), .NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .cancel       (cancel),
    .load_val     (load_val),
    .rd_sel       (rd_sel),
    .busy         (busy),
    .expired      (expired),
    .tick_1ms     (tick_1ms),
    .rd_remaining (rd_remaining)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic set_load(input int ch, input int v);
    load_val[ch*CNT_W +: CNT_W] = CNT_W'(v);
  endtask

  initial begin
    reset = 1'b1; start = '0; cancel = '0; load_val = '0; rd_sel = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tick", 32'(tick_1ms), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_exp", 32'(expired), 32'h0);
    chk("rst_rd", 32'(rd_remaining), 32'h0);
    reset = 1'b0;
    cyc = 0;

    // Idle timebase: tick after edges 4, 8, 12
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("t1_tick", 32'(tick_1ms), 32'((k % TICK_DIV) == 0));
      chk("t1_busy", 32'(busy), 32'h0);
      chk("t1_exp", 32'(expired), 32'h0);
    end

    // ch0 = 3, started on edge 13 alongside a tick (start wins)
    set_load(0, 3); start = 4'b0001; rd_sel = 2'd0;
    step();
    start = '0;
    chk("t2_busy_start", 32'(busy), 32'h1);
    chk("t2_rd_load", 32'(rd_remaining), 32'd3);
    run_to(16); chk("t2_rd16", 32'(rd_remaining), 32'd3);
    run_to(17); chk("t2_rd17", 32'(rd_remaining), 32'd2);
    run_to(21); chk("t2_rd21", 32'(rd_remaining), 32'd1);
    run_to(24);
    chk("t2_rd24", 32'(rd_remaining), 32'd1);
    chk("t2_exp24", 32'(expired), 32'h0);
    chk("t2_busy24", 32'(busy), 32'h1);
    run_to(25);
    chk("t2_busy_exp", 32'(busy), 32'h0);
    chk("t2_exp", 32'(expired), 32'h1);
    chk("t2_rd_zero", 32'(rd_remaining), 32'h0);
    run_to(26); chk("t2_exp_drop", 32'(expired), 32'h0);

    // ch1 started with zero duration
    load_val = '0; start = 4'b0010;
    step();
    start = '0;
    chk("t3_exp", 32'(expired), 32'h2);
    chk("t3_busy", 32'(busy), 32'h0);
    step();
    chk("t3_exp_drop", 32'(expired), 32'h0);
    chk("t3_busy2", 32'(busy), 32'h0);

    // ch2 = 5, cancelled after two decrements
    set_load(2, 5); rd_sel = 2'd2; start = 4'b0100;
    step();
    start = '0;
    chk("t4_busy", 32'(busy), 32'h4);
    chk("t4_rd_load", 32'(rd_remaining), 32'd5);
    run_to(33); chk("t4_rd33", 32'(rd_remaining), 32'd4);
    run_to(37); chk("t4_rd37", 32'(rd_remaining), 32'd3);
    cancel = 4'b0100;
    step();
    cancel = '0;
    chk("t4_busy_cancel", 32'(busy), 32'h0);
    chk("t4_rd_cancel", 32'(rd_remaining), 32'h0);
    chk("t4_exp_cancel", 32'(expired), 32'h0);
    while (cyc < 40) begin
      step();
      chk("t4_no_exp", 32'(expired), 32'h0);
    end
    set_load(2, 7); start = 4'b0100; cancel = 4'b0100;
    step();
    start = '0; cancel = '0;
    chk("t4_sc_busy", 32'(busy), 32'h0);
    chk("t4_sc_rd", 32'(rd_remaining), 32'h0);
    chk("t4_sc_exp", 32'(expired), 32'h0);

    // ch3 = 2, reloaded with 4 on the tick edge where count==1
    set_load(3, 2); rd_sel = 2'd3; start = 4'b1000;
    step();
    start = '0;
    chk("t5_busy", 32'(busy), 32'h8);
    chk("t5_rd_load", 32'(rd_remaining), 32'd2);
    run_to(45); chk("t5_rd45", 32'(rd_remaining), 32'd1);
    run_to(48);
    chk("t5_tick48", 32'(tick_1ms), 32'h1);
    chk("t5_rd48", 32'(rd_remaining), 32'd1);
    set_load(3, 4); start = 4'b1000;
    step();
    start = '0;
    chk("t5_reload_exp", 32'(expired), 32'h0);
    chk("t5_reload_rd", 32'(rd_remaining), 32'd4);
    chk("t5_reload_busy", 32'(busy), 32'h8);
    run_to(53); chk("t5_rd53", 32'(rd_remaining), 32'd3);
    while (cyc < 64) begin
      step();
      chk("t5_no_exp", 32'(expired), 32'h0);
    end
    chk("t5_rd64", 32'(rd_remaining), 32'd1);
    step();
    chk("t5_exp", 32'(expired), 32'h8);
    chk("t5_busy_exp", 32'(busy), 32'h0);
    chk("t5_rd_exp", 32'(rd_remaining), 32'h0);

    // ch0 and ch1 = 2 together -> simultaneous expiry on edge 73
    load_val = '0; set_load(0, 2); set_load(1, 2); start = 4'b0011;
    step();
    start = '0;
    chk("t6_busy", 32'(busy), 32'h3);
    run_to(72);
    chk("t6_busy72", 32'(busy), 32'h3);
    chk("t6_exp72", 32'(expired), 32'h0);
    run_to(73);
    chk("t6_exp", 32'(expired), 32'h3);
    chk("t6_busy_exp", 32'(busy), 32'h0);
    step();
    chk("t6_exp_drop", 32'(expired), 32'h0);

    // Reset while three channels run
    load_val = '0; set_load(0, 2); set_load(1, 2); set_load(2, 2); start = 4'b0111;
    step();
    start = '0;
    chk("t6r_busy", 32'(busy), 32'h7);
    run_to(77);
    rd_sel = 2'd0;
    #1;
    chk("t6r_rd77", 32'(rd_remaining), 32'd1);
    reset = 1'b1;
    #1;
    chk("t6r_busy_rst", 32'(busy), 32'h0);
    chk("t6r_exp_rst", 32'(expired), 32'h0);
    chk("t6r_tick_rst", 32'(tick_1ms), 32'h0);
    chk("t6r_rd_rst", 32'(rd_remaining), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("t6r_tick", 32'(tick_1ms), 32'((k % TICK_DIV) == 0));
      chk("t6r_exp", 32'(expired), 32'h0);
      chk("t6r_busy", 32'(busy), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
